muldiv_unit: RTL

//  Iterative multiply/divide unit producing HI/LO, covering the MULT/MULTU/DIV/DIVU ops

---
 rtl/muldiv_unit_pkg.sv | 28 ++
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared CPU types for the multiply/divide unit: op codes, FSM states, defaults.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    localparam int unsigned MD_CYCLES = 32;

    function automatic logic md_is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bundle of the muldiv handshake and result signals, in the same shape as alu_if.
import cpu_types_pkg::*;

interface muldiv_if #(
    parameter int unsigned WIDTH = MD_CYCLES
) (
    input logic CLK,
    input logic nRST
);
    logic             start;
    logic             abort;
    muldiv_op_t       op;
    logic [WIDTH-1:0] portA;
    logic [WIDTH-1:0] portB;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport dut (
        input  CLK, nRST, start, abort, op, portA, portB,
        output busy, done, div_by_zero, hi, lo
    );

    modport tb (
        input  CLK, nRST, busy, done, div_by_zero, hi, lo,
        output start, abort, op, portA, portB
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide sharing
// one 2*WIDTH shift register, with sign fix-up applied in a single cycle at the end.
import cpu_types_pkg::*;

module muldiv_unit #(
    parameter int unsigned WIDTH = MD_CYCLES
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic             abort,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] portA,
    input  logic [WIDTH-1:0] portB,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    md_state_t          state_q, state_d;
    muldiv_op_t         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // {hi-half, lo-half}: product or {rem, quo}
    logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor (magnitude)
    logic [WIDTH-1:0]   araw_q, araw_d;    // portA as sampled, for divide-by-zero hi
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Operand conditioning at the start edge
    logic               sgn_in, a_neg, b_neg, div_in;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign sgn_in = md_is_signed(op);
    assign div_in = md_is_div(op);
    assign a_neg  = sgn_in & portA[WIDTH-1];
    assign b_neg  = sgn_in & portB[WIDTH-1];
    assign abs_a  = a_neg ? -portA : portA;
    assign abs_b  = b_neg ? -portB : portB;

    // One shift-add multiply step: carry out of the add becomes the new top bit
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {add_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step; the shifted remainder needs WIDTH+1 bits, and when it
    // is >= divisor the true difference is < divisor, so a WIDTH-bit subtract suffices
    logic [WIDTH:0]     rem_sh;
    logic               no_borrow;
    logic [WIDTH-1:0]   rem_diff;
    logic [2*WIDTH-1:0] div_next;

    assign rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    assign no_borrow = (rem_sh >= {1'b0, opnd_q});
    assign rem_diff  = rem_sh[WIDTH-1:0] - opnd_q;
    assign div_next  = no_borrow ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                                 : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    // Sign fix-up of the finished magnitudes
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // State, counter, datapath and result registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= MD_IDLE;
            op_q       <= MD_MULT;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            araw_q     <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            araw_q     <= araw_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Next-state and datapath: abort outranks everything except in IDLE
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        araw_d     = araw_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        if (abort && (state_q != MD_IDLE)) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE, MD_DONE: begin
                    state_d = MD_IDLE;
                    if (start) begin
                        op_d       = op;
                        cnt_d      = '0;
                        araw_d     = portA;
                        neg_res_d  = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        dbz_pend_d = div_in && (portB == '0);
                        if (div_in) begin
                            acc_d  = {{WIDTH{1'b0}}, abs_a};
                            opnd_d = abs_b;
                        end else begin
                            acc_d  = {{WIDTH{1'b0}}, abs_b};
                            opnd_d = abs_a;
                        end
                        state_d = (div_in && (portB == '0)) ? MD_FIX : MD_CALC;
                    end
                end
                MD_CALC: begin
                    acc_d = md_is_div(op_q) ? div_next : mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = MD_FIX;
                    end
                end
                MD_FIX: begin
                    state_d = MD_DONE;
                    dbz_d   = dbz_pend_q;
                    if (dbz_pend_q) begin
                        hi_d = araw_q;
                        lo_d = '1;
                    end else if (md_is_div(op_q)) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    assign busy        = (state_q == MD_CALC) || (state_q == MD_FIX);
    assign done        = (state_q == MD_DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
